mux_stim_checker: RTL

MUX_STIM_CHECKER -- requirements
Module: mux_stim_checker

---
 rtl/mux_stim_checker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mux_stim_checker.sv
// mux_stim_checker: drives a 2:1 mux under test with counter or LFSR vectors,
// predicts its output, and compares the latency-aligned response.
module mux_stim_checker #(
  parameter int         WIDTH       = 4,
  parameter int         NUM_VECTORS = 512,
  parameter int         DUT_LAT     = 1,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             sel,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [9:0]       err_count,
  output logic [9:0]       vec_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0] SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [9:0] LAST_VEC   = 10'(NUM_VECTORS - 1);
  localparam int         DRAIN_LEN  = (DUT_LAT > 0) ? DUT_LAT : 1;
  localparam logic [2:0] LAST_DRAIN = 3'(DRAIN_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic             mode_q;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [9:0]       vec_q;
  logic [2:0]       drain_q;
  logic [9:0]       err_q;
  logic             drive;
  logic             entering;
  logic [3:0]       vec_a, vec_b;
  logic             vec_sel;
  logic [WIDTH-1:0] exp_val;
  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_exp;

  assign drive    = (state_q == DRIVE);
  assign entering = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state selection; start is only honoured from IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = DRIVE;
      DRIVE:      if (vec_q == LAST_VEC) state_d = (DUT_LAT == 0) ? DONE : DRAIN;
      DRAIN:      if (drain_q == LAST_DRAIN) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Fibonacci LFSR step (taps 8,6,5,4) and vector formation from the selected source.
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    vec_a   = mode_q ? lfsr_q[3:0] : vec_q[3:0];
    vec_b   = mode_q ? lfsr_q[7:4] : vec_q[7:4];
    vec_sel = mode_q ? (lfsr_q[0] ^ lfsr_q[7]) : vec_q[8];
    a       = drive ? WIDTH'(vec_a) : '0;
    b       = drive ? WIDTH'(vec_b) : '0;
    sel     = drive & vec_sel;
    exp_val = sel ? b : a;
  end

  // Control registers: state, latched mode, LFSR, vector index and drain timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      lfsr_q  <= SEED_EFF;
      vec_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      if (entering) begin
        mode_q  <= mode;
        lfsr_q  <= SEED_EFF;
        vec_q   <= '0;
        drain_q <= '0;
      end else if (drive) begin
        lfsr_q  <= lfsr_d;
        vec_q   <= vec_q + 10'd1;
      end else if (state_q == DRAIN) begin
        drain_q <= drain_q + 3'd1;
      end
    end
  end

  // Expected-value delay line, matched to the latency of the mux under test.
  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign cmp_valid = drive;
      assign cmp_exp   = exp_val;
    end else begin : g_pipe
      logic             valid_q [DUT_LAT];
      logic [WIDTH-1:0] exp_q   [DUT_LAT];

      // Shift expected value and its valid bit one stage per clock.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DUT_LAT; i++) begin
            valid_q[i] <= 1'b0;
            exp_q[i]   <= '0;
          end
        end else begin
          valid_q[0] <= drive;
          exp_q[0]   <= exp_val;
          for (int i = 1; i < DUT_LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            exp_q[i]   <= exp_q[i-1];
          end
        end
      end

      assign cmp_valid = valid_q[DUT_LAT-1];
      assign cmp_exp   = exp_q[DUT_LAT-1];
    end
  endgenerate

  // Mismatch counter: cleared on run start, saturates at 1023.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (entering) begin
      err_q <= '0;
    end else if (cmp_valid && (y != cmp_exp) && (err_q != 10'h3FF)) begin
      err_q <= err_q + 10'd1;
    end
  end

  assign busy      = drive || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == 10'd0);
  assign err_count = err_q;
  assign vec_count = vec_q;

endmodule
